// File: rtl/crc_frame_serializer.sv
// Parallel-to-serial framer: shifts a payload word out MSB-first, then a CRC_W-bit trailer.
// Build option: define CRC_APPEND_EN to send the computed CRC as the trailer (default: zeros).
module crc_frame_serializer #(
   parameter int               DATA_W = 32,
   parameter int               CRC_W  = 8,
   parameter logic [CRC_W-1:0] POLY   = 8'h07
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] data_in,
   input  logic              data_valid,
   output logic              data_ready,
   output logic              ser_out,
   output logic              ser_valid,
   output logic              sof,
   output logic              eof,
   output logic [CRC_W-1:0]  crc_out
);

   localparam int FRAME_LEN = DATA_W + CRC_W;
   localparam int CNT_W     = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);
   localparam logic [CNT_W-1:0] TAIL_IDX = CNT_W'(DATA_W);

   typedef enum logic [1:0] {IDLE, DATA, TAIL} state_t;

   state_t             state_reg;
   logic [DATA_W-1:0]  shift_reg;
   logic [CRC_W-1:0]   lfsr_reg;
   logic [CRC_W-1:0]   crc_reg;
   logic [CNT_W-1:0]   bit_cnt_reg;
   logic               ser_out_reg;
   logic               ser_valid_reg;
   logic               sof_reg;
   logic               eof_reg;
`ifdef CRC_APPEND_EN
   logic [CRC_W-1:0]   tail_reg;
`endif

   logic               accept;
   logic [CNT_W-1:0]   next_idx;

   function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] c, input logic b);
      logic [CRC_W-1:0] r;
      r = c << 1;
      if (c[CRC_W-1] ^ b)
         r = r ^ POLY;
      return r;
   endfunction

   // Ready while idle or while the last trailer bit is on the wire, so frames can abut.
   assign data_ready = rst_n && (state_reg == IDLE || eof_reg);
   assign accept     = data_valid && data_ready;
   assign next_idx   = bit_cnt_reg + CNT_W'(1);

   assign ser_out   = ser_out_reg;
   assign ser_valid = ser_valid_reg;
   assign sof       = sof_reg;
   assign eof       = eof_reg;
   assign crc_out   = crc_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         shift_reg     <= '0;
         lfsr_reg      <= '0;
         crc_reg       <= '0;
         bit_cnt_reg   <= '0;
         ser_out_reg   <= 1'b0;
         ser_valid_reg <= 1'b0;
         sof_reg       <= 1'b0;
         eof_reg       <= 1'b0;
`ifdef CRC_APPEND_EN
         tail_reg      <= '0;
`endif
      end else begin
         sof_reg <= 1'b0;
         eof_reg <= 1'b0;
         if (state_reg == IDLE || eof_reg) begin
            if (accept) begin
               // The first bit goes out straight away; the LFSR starts from zero with it.
               state_reg     <= DATA;
               bit_cnt_reg   <= '0;
               ser_out_reg   <= data_in[DATA_W-1];
               ser_valid_reg <= 1'b1;
               sof_reg       <= 1'b1;
               shift_reg     <= data_in << 1;
               lfsr_reg      <= crc_step('0, data_in[DATA_W-1]);
            end else begin
               state_reg     <= IDLE;
               ser_out_reg   <= 1'b0;
               ser_valid_reg <= 1'b0;
            end
         end else begin
            bit_cnt_reg <= next_idx;
            eof_reg     <= (next_idx == LAST_IDX);
            if (next_idx < TAIL_IDX) begin
               ser_out_reg <= shift_reg[DATA_W-1];
               shift_reg   <= shift_reg << 1;
               lfsr_reg    <= crc_step(lfsr_reg, shift_reg[DATA_W-1]);
            end else if (next_idx == TAIL_IDX) begin
               state_reg <= TAIL;
               crc_reg   <= lfsr_reg;
`ifdef CRC_APPEND_EN
               ser_out_reg <= lfsr_reg[CRC_W-1];
               tail_reg    <= lfsr_reg << 1;
`else
               ser_out_reg <= 1'b0;
`endif
            end else begin
`ifdef CRC_APPEND_EN
               ser_out_reg <= tail_reg[CRC_W-1];
               tail_reg    <= tail_reg << 1;
`else
               ser_out_reg <= 1'b0;
`endif
            end
         end
      end
   end

endmodule

// File: tb/tb_crc_frame_serializer.sv
// Directed bench for crc_frame_serializer: expected frames are queued on accept and
// popped bit by bit as the serializer emits them.
module tb_crc_frame_serializer;

   localparam int DW = 32;
   localparam int CW = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [DW-1:0] data_in = '0;
   logic          data_valid = 1'b0;
   logic          data_ready;
   logic          ser_out;
   logic          ser_valid;
   logic          sof;
   logic          eof;
   logic [CW-1:0] crc_out;

   crc_frame_serializer #(.DATA_W(DW), .CRC_W(CW), .POLY(8'h07)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .data_in    (data_in),
      .data_valid (data_valid),
      .data_ready (data_ready),
      .ser_out    (ser_out),
      .ser_valid  (ser_valid),
      .sof        (sof),
      .eof        (eof),
      .crc_out    (crc_out)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic          b;
      logic          s;
      logic          e;
      logic          t;
      logic [CW-1:0] crc;
      logic [CW-1:0] res;
   } exp_t;

   exp_t          exp_q[$];
   int            total = 0;
   int            bad = 0;
   logic          model_ready = 1'b1;
   logic [CW-1:0] model_crc = '0;
   logic [CW-1:0] obs_crc = '0;
   int            run_len = 0;
   int            last_run = 0;

   function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic b);
      if (c[7] ^ b)
         return {c[6:0], 1'b0} ^ 8'h07;
      return {c[6:0], 1'b0};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic push_frame(input logic [DW-1:0] w);
      logic [7:0] c;
      logic [7:0] r;
      logic       tb;
      exp_t       e;
      c = '0;
      for (int i = DW - 1; i >= 0; i--)
         c = crc8_step(c, w[i]);
      r = '0;
      for (int i = DW - 1; i >= 0; i--) begin
         r = crc8_step(r, w[i]);
         e = '{b: w[i], s: (i == DW - 1), e: 1'b0, t: 1'b0, crc: c, res: '0};
         exp_q.push_back(e);
      end
      for (int j = CW - 1; j >= 0; j--) begin
`ifdef CRC_APPEND_EN
         tb = c[j];
`else
         tb = 1'b0;
`endif
         r = crc8_step(r, tb);
         e = '{b: tb, s: 1'b0, e: (j == 0), t: 1'b1, crc: c, res: r};
         exp_q.push_back(e);
      end
      $display("accept word=%h expected_crc=%h residue=%h", w, c, r);
   endtask

   task automatic check_outputs();
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("ser_valid", ser_valid, 1);
         check("ser_out", ser_out, e.b);
         check("sof", sof, e.s);
         check("eof", eof, e.e);
         if (e.t)
            model_crc = e.crc;
         check("crc_out", crc_out, model_crc);
         obs_crc = e.s ? crc8_step(8'h00, ser_out) : crc8_step(obs_crc, ser_out);
         if (e.e)
            check("stream_residue", obs_crc, e.res);
         model_ready = e.e;
      end else begin
         check("idle_ser_valid", ser_valid, 0);
         check("idle_ser_out", ser_out, 0);
         check("idle_sof", sof, 0);
         check("idle_eof", eof, 0);
         check("idle_crc_out", crc_out, model_crc);
         model_ready = 1'b1;
      end
      check("data_ready", data_ready, rst_n && model_ready);
      if (ser_valid === 1'b1) begin
         run_len++;
      end else begin
         if (run_len != 0)
            last_run = run_len;
         run_len = 0;
      end
   endtask

   // One clock: decide acceptance from the model, then check outputs on the falling edge.
   task automatic cyc();
      logic acc;
      acc = data_valid && rst_n && model_ready;
      @(posedge clk);
      if (acc)
         push_frame(data_in);
      @(negedge clk);
      check_outputs();
   endtask

   initial begin
      // Reset held for three cycles
      repeat (3) cyc();
      check("reset_crc_out", crc_out, 0);
      rst_n = 1'b1;
      #1;
      check("ready_after_release", data_ready, 1);
      check("idle_after_release", ser_valid, 0);

      // Single frame
      data_in = 32'h0000000D;
      data_valid = 1'b1;
      cyc();
      data_valid = 1'b0;
      repeat (39) cyc();
      check("frame_a_crc", crc_out, 8'h23);
      repeat (3) cyc();

      // Back-to-back frames with data_valid held
      data_in = 32'h0000000D;
      data_valid = 1'b1;
      cyc();
      data_in = 32'h00000000;
      repeat (39) cyc();
      cyc();
      data_valid = 1'b0;
      repeat (39) cyc();
      check("b2b_second_crc", crc_out, 8'h00);
      repeat (2) cyc();
      check("b2b_run_length", last_run, 80);

      // Busy frame: input activity during the frame must be ignored
      data_in = 32'h0000000D;
      data_valid = 1'b1;
      cyc();
      data_valid = 1'b0;
      for (int k = 2; k <= 40; k++) begin
         if (k >= 5 && k <= 20) begin
            data_valid = k[0];
            data_in = 32'hFFFFFFFF;
         end else if (k > 20) begin
            data_valid = 1'b1;
         end
         cyc();
      end
      check("busy_frame_crc", crc_out, 8'h23);
      cyc();
      data_valid = 1'b0;
      repeat (39) cyc();
      repeat (2) cyc();

      // Mid-frame asynchronous reset
      data_in = 32'h0000000D;
      data_valid = 1'b1;
      cyc();
      data_valid = 1'b0;
      repeat (9) cyc();
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_ser_valid", ser_valid, 0);
      check("async_rst_ser_out", ser_out, 0);
      check("async_rst_sof", sof, 0);
      check("async_rst_eof", eof, 0);
      check("async_rst_crc_out", crc_out, 0);
      check("async_rst_ready", data_ready, 0);
      exp_q.delete();
      model_ready = 1'b1;
      model_crc = '0;
      repeat (2) cyc();
      rst_n = 1'b1;
      data_in = 32'h0000000D;
      data_valid = 1'b1;
      cyc();
      data_valid = 1'b0;
      repeat (39) cyc();
      check("post_reset_crc", crc_out, 8'h23);
      repeat (3) cyc();
      check("queue_drained", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/crc_frame_serializer.md
# crc_frame_serializer

Parallel-to-serial framer feeding the serial CRC-8 stage. It accepts a DATA_W-bit word over a valid/ready handshake and shifts it out MSB-first, one bit per clock. It then emits a CRC_W-bit trailer: zeros, forming the augmented message the downstream serial CRC expects, or the computed CRC itself. It drives the downstream stage's serial input and marks frame boundaries so that stage can be re-armed per frame.

## Interface
- DATA_W, 32, payload width in bits (≥1)
- CRC_W, 8, trailer width in bits
- POLY, 8'h07, CRC generator polynomial without the implicit x^CRC_W term; non-reflected, init 0, no final XOR

- CLK  in  1  rising-edge clock
- RST  in  1  asynchronous, active-low reset
- data_in  in  DATA_W  payload word, sampled on accept
- data_valid  in  1  payload offered
- data_ready  out  1  block can accept a payload this cycle
- ser_out  out  1  serial bit, MSB-first
- ser_valid  out  1  ser_out carries a frame bit
- sof  out  1  high with the first bit of a frame
- eof  out  1  high with the last bit of a frame
- crc_out  out  CRC_W  CRC of the most recently completed frame's payload

## Operation
- States: IDLE, DATA, TAIL.
- Accept: data_valid && data_ready at a rising edge.
- data_ready = RST && (state==IDLE || eof). It is combinational from registered state and is forced 0 while RST is low.
- IDLE + accept → DATA:
  - Load shift register from data_in.
  - Clear the internal LFSR to 0.
  - bit_cnt = 0.
- DATA: ser_out = shift[DATA_W-1] each cycle, then shift left.
  - LFSR update per bit: fb = lfsr[CRC_W-1] ^ bit; lfsr = (lfsr<<1) ^ (fb ? POLY : 0).
  - After DATA_W bits → TAIL.
- TAIL: emits CRC_W bits.
  - The trailer source is chosen by the Configuration macro.
  - The LFSR value after the payload is captured into crc_out on the first TAIL cycle.
- Last TAIL bit (eof=1):
  - If an accept occurs in the same cycle → DATA with the new word; no gap cycle.
  - Otherwise → IDLE.
- Frame length is DATA_W+CRC_W cycles of ser_valid. bit_cnt is wide enough for DATA_W+CRC_W-1 and never wraps within a frame.
- data_valid while not ready is ignored. data_in changes during a frame have no effect.
- Reset values: ser_out 0, ser_valid 0, sof 0, eof 0, crc_out 0, state IDLE, LFSR 0.
- Reset mid-frame aborts the frame immediately; there is no partial-frame completion. The next accept after release starts a fresh frame with the LFSR at 0.

## Timing
- All outputs except data_ready are registered.
- Accept at edge N → first bit (sof=1, ser_valid=1) valid after edge N. Latency is 1 cycle.
- Bit k (1-based) of the frame is valid after edge N+k-1. eof is high with bit DATA_W+CRC_W.
- sof and eof are each high for exactly one cycle per frame. They coincide only if DATA_W+CRC_W==1, which is not supported.
- Back-to-back: if data_valid is held, the next sof follows eof in the very next cycle. ser_valid stays continuously high.
- crc_out updates one cycle after the last payload bit and holds until the next frame's trailer.
- Idle: ser_valid 0, ser_out 0.

## Configuration
- CRC_APPEND_EN defined: TAIL shifts out the captured CRC MSB-first. Running the whole frame through a CRC with the same polynomial then yields remainder 0.
- CRC_APPEND_EN undefined: TAIL shifts out CRC_W zeros. The stream is the augmented message {data, CRC_W'h0} consumed by the downstream serial CRC stage. crc_out is still computed and updated.

## Test plan
- Reset: hold RST low for 3 cycles → all outputs 0 and data_ready 0. After release → data_ready 1 and ser_valid 0.
- Macro undefined, accept 32'h0000000D → 40 bits: 28 zeros, then 1101, then 8 zeros.
  - sof on bit 1, eof on bit 40.
  - crc_out = 8'h23.
  - data_ready 0 on bits 1–39 and 1 on bit 40.
- Macro defined, same word → bits 33–40 = 00100011 (8'h23). Feeding all 40 bits through an independent CRC-8/0x07 model gives 8'h00.
- Back-to-back: data_valid held with 32'h0000000D, then 32'h00000000 → 80 contiguous ser_valid cycles. Second sof is in the cycle right after the first eof. Second crc_out = 8'h00.
- Busy ignore: during frame bits 5–20, toggle data_valid and change data_in to 32'hFFFFFFFF → no accept and unchanged serial output. The next accept happens only at or after eof.
- Mid-frame reset: drop RST at bit 10 → outputs 0 asynchronously. After release, accept 32'h0000000D → a full correct 40-bit frame with crc_out = 8'h23.
